// File: rtl/audio_mixer_sd_pkg.sv
// Shared types and constants for the sigma-delta audio mixer.
package audio_mixer_sd_pkg;

  typedef enum logic [1:0] {
    PAN_OFF  = 2'b00,
    PAN_L    = 2'b01,
    PAN_R    = 2'b10,
    PAN_BOTH = 2'b11
  } pan_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC,
    ST_LATCH
  } state_t;

  localparam int CFG_VOL_LSB = 0;
  localparam int CFG_VOL_W   = 4;
  localparam int CFG_PAN_LSB = 4;
  localparam int CFG_PAN_W   = 2;
  localparam int CFG_W       = CFG_VOL_W + CFG_PAN_W;

  // Field order matches the cfg_data layout: pan in [5:4], volume in [3:0].
  typedef struct packed {
    pan_t       pan;
    logic [3:0] vol;
  } cfg_t;

  localparam logic [3:0] VOL_RST = 4'hF;
  localparam pan_t       PAN_RST = PAN_BOTH;
  localparam cfg_t       CFG_RST = '{pan: PAN_RST, vol: VOL_RST};

endpackage

// File: rtl/audio_mixer_sd_if.sv
// Per-channel configuration bus: write strobe/address/data plus readback of the live register.
interface audio_mixer_sd_if;
  import audio_mixer_sd_pkg::*;

  logic             cfg_we;
  logic [2:0]       cfg_addr;
  logic [CFG_W-1:0] cfg_data;
  logic [CFG_W-1:0] cfg_rdata;

  modport master (output cfg_we, cfg_addr, cfg_data, input cfg_rdata);
  modport slave  (input cfg_we, cfg_addr, cfg_data, output cfg_rdata);
endinterface

// File: rtl/audio_mixer_sd_dac1.sv
// First-order sigma-delta modulator; the carry out of the integrator is the output bit.
module sd_dac1 #(
  parameter int DW = 10
) (
  input  logic          clk_sys,
  input  logic          nRESET,
  input  logic          ce_i,
  input  logic [DW-1:0] mix_i,
  output logic          audio_o
);
  logic [DW:0] int_q, int_d;

  always_comb int_d = {1'b0, int_q[DW-1:0]} + {1'b0, mix_i};

  always_ff @(posedge clk_sys) begin
    if (!nRESET)   int_q <= '0;
    else if (ce_i) int_q <= int_d;
  end

  assign audio_o = int_q[DW];
endmodule

// File: rtl/audio_mixer_sd.sv
// N-channel volume/pan mixer with beeper/tape bits, one shared MAC, two sigma-delta outputs.
// state    | meaning
// ST_IDLE  | wait for ce_sample; snapshot inputs and cfg, seed accumulators with beeper term
// ST_ACC   | one channel multiply-accumulate per cycle
// ST_LATCH | saturate, publish mix, pulse sample_valid
module audio_mixer_sd
  import audio_mixer_sd_pkg::*;
#(
  parameter int NCH      = 3,
  parameter int W        = 8,
  parameter int DW       = 10,
  parameter int BEEP_LVL = 64
) (
  input  logic             clk_sys,
  input  logic             nRESET,
  input  logic             ce_sample,
  input  logic             ce_dac,
  audio_mixer_sd_if.slave  cfg,
  input  logic [NCH*W-1:0] ch_in,
  input  logic             ear_out,
  input  logic             mic_out,
  input  logic             tape_in,
  output logic             AUDIO_L,
  output logic             AUDIO_R,
  output logic             sample_valid,
  output logic             clip,
  output logic             overrun
);
  // Accumulator sized for the worst-case sum so nothing wraps before saturation.
  localparam int ACC_MAX = NCH * (2**W - 1) + BEEP_LVL + BEEP_LVL / 2 + BEEP_LVL / 4;
  localparam int AW_MIN  = $clog2(ACC_MAX + 1);
  localparam int AW      = (AW_MIN > DW + 1) ? AW_MIN : DW + 1;
  localparam int IW      = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [AW-1:0] MIX_MAX = AW'((2**DW) - 1);

  state_t        state_q, state_d;
  cfg_t          cfg_q [NCH];
  cfg_t          cfg_d [NCH];
  cfg_t          sh_q  [NCH];
  cfg_t          sh_d  [NCH];
  logic [W-1:0]  chs_q [NCH];
  logic [W-1:0]  chs_d [NCH];
  logic [IW-1:0] idx_q, idx_d;
  logic [AW-1:0] acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic [DW-1:0] mix_l_q, mix_l_d, mix_r_q, mix_r_d;
  logic          valid_q, valid_d, clip_q, clip_d, overrun_c;
  logic [AW-1:0] beep_term;
  cfg_t          sel_cfg;
  logic [W-1:0]  sel_ch;
  logic [W+3:0]  prod;
  logic [W-1:0]  p;
  logic          sat_l, sat_r;

  always_comb begin
    cfg_d         = cfg_q;
    cfg.cfg_rdata = '0;
    for (int i = 0; i < NCH; i++) begin
      if (cfg.cfg_we && cfg.cfg_addr == 3'(i)) cfg_d[i] = cfg_t'(cfg.cfg_data);
      if (cfg.cfg_addr == 3'(i))               cfg.cfg_rdata = cfg_q[i];
    end
  end

  always_comb begin
    sel_cfg = sh_q[0];
    sel_ch  = chs_q[0];
    for (int i = 1; i < NCH; i++) begin
      if (idx_q == IW'(i)) begin
        sel_cfg = sh_q[i];
        sel_ch  = chs_q[i];
      end
    end
    prod = (W+4)'(sel_ch) * (W+4)'(sel_cfg.vol);
    p    = W'(prod >> 4);
  end

  always_comb begin
    beep_term = (ear_out ? AW'(BEEP_LVL)     : '0)
              + (mic_out ? AW'(BEEP_LVL / 2) : '0)
              + (tape_in ? AW'(BEEP_LVL / 4) : '0);
    sat_l = acc_l_q > MIX_MAX;
    sat_r = acc_r_q > MIX_MAX;
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_l_d   = acc_l_q;
    acc_r_d   = acc_r_q;
    sh_d      = sh_q;
    chs_d     = chs_q;
    mix_l_d   = mix_l_q;
    mix_r_d   = mix_r_q;
    valid_d   = 1'b0;
    clip_d    = 1'b0;
    overrun_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (ce_sample) begin
          for (int i = 0; i < NCH; i++) chs_d[i] = ch_in[i*W +: W];
          sh_d    = cfg_q;
          idx_d   = '0;
          acc_l_d = beep_term;
          acc_r_d = beep_term;
          state_d = ST_ACC;
        end
      end
      ST_ACC: begin
        overrun_c = ce_sample;
        if (sel_cfg.pan[0]) acc_l_d = acc_l_q + AW'(p);
        if (sel_cfg.pan[1]) acc_r_d = acc_r_q + AW'(p);
        if (idx_q == IW'(NCH - 1)) state_d = ST_LATCH;
        else                       idx_d   = idx_q + IW'(1);
      end
      ST_LATCH: begin
        overrun_c = ce_sample;
        mix_l_d   = sat_l ? '1 : acc_l_q[DW-1:0];
        mix_r_d   = sat_r ? '1 : acc_r_q[DW-1:0];
        valid_d   = 1'b1;
        clip_d    = sat_l | sat_r;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!nRESET) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      acc_l_q <= '0;
      acc_r_q <= '0;
      mix_l_q <= '0;
      mix_r_q <= '0;
      valid_q <= 1'b0;
      clip_q  <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        cfg_q[i] <= CFG_RST;
        sh_q[i]  <= CFG_RST;
        chs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_l_q <= acc_l_d;
      acc_r_q <= acc_r_d;
      mix_l_q <= mix_l_d;
      mix_r_q <= mix_r_d;
      valid_q <= valid_d;
      clip_q  <= clip_d;
      cfg_q   <= cfg_d;
      sh_q    <= sh_d;
      chs_q   <= chs_d;
    end
  end

  assign sample_valid = valid_q;
  assign clip         = clip_q;
  assign overrun      = overrun_c & nRESET;

  sd_dac1 #(.DW(DW)) u_dac_l (
    .clk_sys (clk_sys),
    .nRESET  (nRESET),
    .ce_i    (ce_dac),
    .mix_i   (mix_l_q),
    .audio_o (AUDIO_L)
  );

  sd_dac1 #(.DW(DW)) u_dac_r (
    .clk_sys (clk_sys),
    .nRESET  (nRESET),
    .ce_i    (ce_dac),
    .mix_i   (mix_r_q),
    .audio_o (AUDIO_R)
  );
endmodule
